// File: rtl/dp_tcdm_arbiter.sv
// Dual-port TCDM arbiter: two requesters share one memory port.
// Round-robin selection with a registered "pending" hold while the memory
// stalls, plus an in-order ID FIFO that steers responses back to the
// requester that issued them.
// Optional burst lock is built when DP_TCDM_ARB_LOCK_EN is defined.
//
// Handshake semantics: a request transfers in the cycle where mem_req_o and
// mem_gnt_i are both high. The requester's gnt_o is that same condition
// qualified by its own selection. A response transfers in the cycle where
// mem_r_valid_i is high; it is routed combinationally to the FIFO head ID.
module dp_tcdm_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    dp0_req_i,
    output logic                    dp0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   dp0_add_i,
    input  logic                    dp0_wen_i,
    input  logic [DATA_WIDTH/8-1:0] dp0_be_i,
    input  logic [DATA_WIDTH-1:0]   dp0_data_i,
    output logic                    dp0_r_valid_o,
    output logic [DATA_WIDTH-1:0]   dp0_r_data_o,
    input  logic                    dp1_req_i,
    output logic                    dp1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   dp1_add_i,
    input  logic                    dp1_wen_i,
    input  logic [DATA_WIDTH/8-1:0] dp1_be_i,
    input  logic [DATA_WIDTH-1:0]   dp1_data_i,
    output logic                    dp1_r_valid_o,
    output logic [DATA_WIDTH-1:0]   dp1_r_data_o,
`ifdef DP_TCDM_ARB_LOCK_EN
    input  logic                    dp0_lock_i,
    input  logic                    dp1_lock_i,
`endif
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_add_o,
    output logic                    mem_wen_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   mem_r_data_i,
    output logic                    err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             last_q, last_d;          // last granted requester (1 = dp1)
    logic             pending_q, pending_d;    // stalled request being held
    logic             pending_id_q, pending_id_d;
    logic             id_q [MAX_OUTSTANDING];
    logic             id_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic full, any_req, lock_hold, sel_id, handshake, pop, head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requester selection and shared request path (no added latency).
    always_comb begin
        full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
        any_req = dp0_req_i | dp1_req_i;
`ifdef DP_TCDM_ARB_LOCK_EN
        lock_hold = last_q ? (dp1_lock_i & dp1_req_i) : (dp0_lock_i & dp0_req_i);
`else
        lock_hold = 1'b0;
`endif
        // A stalled request keeps priority so the memory sees stable inputs.
        if (pending_q && (pending_id_q ? dp1_req_i : dp0_req_i)) begin
            sel_id = pending_id_q;
        end else if (lock_hold) begin
            sel_id = last_q;
        end else if (dp0_req_i && dp1_req_i) begin
            sel_id = ~last_q;
        end else begin
            sel_id = dp1_req_i;
        end

        mem_req_o  = any_req & ~full;
        mem_add_o  = '0;
        mem_wen_o  = 1'b0;
        mem_be_o   = '0;
        mem_data_o = '0;
        if (mem_req_o) begin
            mem_add_o  = sel_id ? dp1_add_i  : dp0_add_i;
            mem_wen_o  = sel_id ? dp1_wen_i  : dp0_wen_i;
            mem_be_o   = sel_id ? dp1_be_i   : dp0_be_i;
            mem_data_o = sel_id ? dp1_data_i : dp0_data_i;
        end

        handshake = mem_req_o & mem_gnt_i;
        dp0_gnt_o = handshake & ~sel_id;
        dp1_gnt_o = handshake &  sel_id;

        // Response steering from the FIFO head.
        pop           = mem_r_valid_i & (cnt_q != '0);
        head_id       = id_q[rptr_q];
        dp0_r_valid_o = pop & ~head_id;
        dp1_r_valid_o = pop &  head_id;
        dp0_r_data_o  = mem_r_data_i;
        dp1_r_data_o  = mem_r_data_i;
        err_o         = err_q;
    end

    // Next-state for pointer, pending hold, ID FIFO and error flag.
    always_comb begin
        last_d       = last_q;
        pending_d    = mem_req_o & ~mem_gnt_i;
        pending_id_d = sel_id;
        id_d         = id_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        if (handshake) begin
            last_d       = sel_id;
            id_d[wptr_q] = sel_id;
            wptr_d       = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({handshake, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (mem_r_valid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end

        // Clear wins over any push/pop in the same cycle.
        if (clear_i) begin
            last_d    = 1'b1;
            pending_d = 1'b0;
            wptr_d    = '0;
            rptr_d    = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
        end
    end

    // State registers; reset leaves dp1 as last granted so dp0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q       <= 1'b1;
            pending_q    <= 1'b0;
            pending_id_q <= 1'b0;
            id_q         <= '{default: 1'b0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            last_q       <= last_d;
            pending_q    <= pending_d;
            pending_id_q <= pending_id_d;
            id_q         <= id_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_dp_tcdm_arbiter.sv
// Self-checking bench for dp_tcdm_arbiter: directed steps, a memory model
// returning f(address) after a fixed latency, and an expected-response queue.
module tb_dp_tcdm_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    // Clock / reset
    logic clk_i = 1'b0;
    logic rst_ni;
    logic clear_i;
    always #5 clk_i = ~clk_i;

    logic          dp0_req_i, dp0_gnt_o, dp0_wen_i, dp0_r_valid_o;
    logic [AW-1:0] dp0_add_i;
    logic [DW/8-1:0] dp0_be_i;
    logic [DW-1:0] dp0_data_i, dp0_r_data_o;
    logic          dp1_req_i, dp1_gnt_o, dp1_wen_i, dp1_r_valid_o;
    logic [AW-1:0] dp1_add_i;
    logic [DW/8-1:0] dp1_be_i;
    logic [DW-1:0] dp1_data_i, dp1_r_data_o;
`ifdef DP_TCDM_ARB_LOCK_EN
    logic          dp0_lock_i, dp1_lock_i;
`endif
    logic          mem_req_o, mem_wen_o, mem_gnt_i, mem_r_valid_i, err_o;
    logic [AW-1:0] mem_add_o;
    logic [DW/8-1:0] mem_be_o;
    logic [DW-1:0] mem_data_o, mem_r_data_i;

    dp_tcdm_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .dp0_req_i(dp0_req_i), .dp0_gnt_o(dp0_gnt_o), .dp0_add_i(dp0_add_i),
        .dp0_wen_i(dp0_wen_i), .dp0_be_i(dp0_be_i), .dp0_data_i(dp0_data_i),
        .dp0_r_valid_o(dp0_r_valid_o), .dp0_r_data_o(dp0_r_data_o),
        .dp1_req_i(dp1_req_i), .dp1_gnt_o(dp1_gnt_o), .dp1_add_i(dp1_add_i),
        .dp1_wen_i(dp1_wen_i), .dp1_be_i(dp1_be_i), .dp1_data_i(dp1_data_i),
        .dp1_r_valid_o(dp1_r_valid_o), .dp1_r_data_o(dp1_r_data_o),
`ifdef DP_TCDM_ARB_LOCK_EN
        .dp0_lock_i(dp0_lock_i), .dp1_lock_i(dp1_lock_i),
`endif
        .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
        .mem_be_o(mem_be_o), .mem_data_o(mem_data_o), .mem_gnt_i(mem_gnt_i),
        .mem_r_valid_i(mem_r_valid_i), .mem_r_data_i(mem_r_data_i), .err_o(err_o)
    );

    // Scoreboard and memory model state
    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } resp_t;
    resp_t         resp_q[$];
    logic [DW:0]   exp_q[$];   // {requester id, response data}
    int            n_tests = 0;
    int            n_fails = 0;
    int            cyc = 0;
    int            gnt0_cnt = 0;
    int            gnt1_cnt = 0;
    bit            auto_resp = 1'b1;

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sched(input int due, input logic [DW-1:0] data);
        resp_t r;
        r.due  = due;
        r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic expect_rsp(input logic id, input logic [AW-1:0] addr);
        exp_q.push_back({id, f(addr)});
    endtask

    // Drive this cycle's response, let logic settle, run memory model and monitor.
    task automatic settle();
        logic [DW:0] e;
        mem_r_valid_i = 1'b0;
        mem_r_data_i  = '0;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            mem_r_valid_i = 1'b1;
            mem_r_data_i  = resp_q[0].data;
            void'(resp_q.pop_front());
        end
        #1;
        if (mem_req_o && mem_gnt_i) begin
            if (dp0_gnt_o) gnt0_cnt++;
            if (dp1_gnt_o) gnt1_cnt++;
            if (auto_resp) sched(cyc + 2, f(mem_add_o));
        end
        if (dp0_r_valid_o || dp1_r_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {dp1_r_valid_o, dp0_r_valid_o}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", {dp1_r_valid_o, dp0_r_valid_o}, e[DW] ? 2'b10 : 2'b01);
                chk("rsp_data0", dp0_r_data_o, e[DW-1:0]);
                chk("rsp_data1", dp1_r_data_o, e[DW-1:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic drain();
        int budget = 20;
        while ((resp_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            settle();
            tick();
            budget--;
        end
        chk("drain_exp_empty", exp_q.size(), 0);
    endtask

    // Safety net against a hang
    initial begin
        #200000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0;
        dp0_req_i = 0; dp0_add_i = '0; dp0_wen_i = 1'b1; dp0_be_i = '1; dp0_data_i = '0;
        dp1_req_i = 0; dp1_add_i = '0; dp1_wen_i = 1'b1; dp1_be_i = '1; dp1_data_i = '0;
`ifdef DP_TCDM_ARB_LOCK_EN
        dp0_lock_i = 1'b0; dp1_lock_i = 1'b0;
`endif
        mem_gnt_i = 1'b1; mem_r_valid_i = 1'b0; mem_r_data_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_add", mem_add_o, 0);
        chk("rst_gnt", {dp1_gnt_o, dp0_gnt_o}, 0);
        chk("rst_rvalid", {dp1_r_valid_o, dp0_r_valid_o}, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // dp0 alone: three reads, 2-cycle latency
        gnt0_cnt = 0; gnt1_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            dp0_req_i = 1'b1;
            dp0_add_i = 32'h100 + 32'(4 * i);
            expect_rsp(1'b0, dp0_add_i);
            settle();
            chk("t1_gnt0", dp0_gnt_o, 1);
            chk("t1_add", mem_add_o, 32'h100 + 32'(4 * i));
            chk("t1_wen", mem_wen_o, 1);
            tick();
        end
        dp0_req_i = 1'b0;
        drain();
        chk("t1_gnt0_total", gnt0_cnt, 3);
        chk("t1_gnt1_total", gnt1_cnt, 0);

        // Clear restores pointer; continuous contention alternates
        clear_i = 1'b1; settle(); tick(); clear_i = 1'b0;
        dp0_req_i = 1'b1; dp0_add_i = 32'h200;
        dp1_req_i = 1'b1; dp1_add_i = 32'h300; dp1_wen_i = 1'b0; dp1_data_i = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            expect_rsp(i[0], i[0] ? 32'h300 : 32'h200);
            settle();
            chk("t2_gnt", {dp1_gnt_o, dp0_gnt_o}, i[0] ? 2'b10 : 2'b01);
            chk("t2_wen", mem_wen_o, i[0] ? 0 : 1);
            chk("t2_data", mem_data_o, i[0] ? 32'h1234_5678 : 32'h0);
            tick();
        end
        dp0_req_i = 1'b0; dp1_req_i = 1'b0; dp1_wen_i = 1'b1;
        drain();

        // Stall holds dp0 even when dp1 rises and would win round-robin
        dp0_req_i = 1'b1; dp0_add_i = 32'h400;
        expect_rsp(1'b0, 32'h400);
        settle();
        chk("t3_first_gnt", {dp1_gnt_o, dp0_gnt_o}, 2'b01);
        tick();
        mem_gnt_i = 1'b0; dp0_add_i = 32'h404;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                dp1_req_i = 1'b1; dp1_add_i = 32'h500;
            end
            settle();
            chk("t3_hold_add", mem_add_o, 32'h404);
            chk("t3_no_gnt", {dp1_gnt_o, dp0_gnt_o}, 0);
            tick();
        end
        mem_gnt_i = 1'b1;
        expect_rsp(1'b0, 32'h404);
        settle();
        chk("t3_dp0_gnt", {dp1_gnt_o, dp0_gnt_o}, 2'b01);
        chk("t3_dp0_add", mem_add_o, 32'h404);
        tick();
        dp0_req_i = 1'b0;
        expect_rsp(1'b1, 32'h500);
        settle();
        chk("t3_dp1_gnt", {dp1_gnt_o, dp0_gnt_o}, 2'b10);
        chk("t3_dp1_add", mem_add_o, 32'h500);
        tick();
        dp1_req_i = 1'b0;
        drain();

        // Fill to MAX_OUTSTANDING with no responses
        auto_resp = 1'b0;
        dp0_req_i = 1'b1;
        for (int i = 0; i < MO; i++) begin
            dp0_add_i = 32'h600 + 32'(4 * i);
            expect_rsp(1'b0, dp0_add_i);
            settle();
            chk("t4_fill_gnt", dp0_gnt_o, 1);
            tick();
        end
        settle();
        chk("t4_full_req", mem_req_o, 0);
        chk("t4_full_gnt", dp0_gnt_o, 0);
        tick();
        sched(cyc, f(32'h600));
        settle();
        chk("t4_full_during_rsp", mem_req_o, 0);
        tick();
        mem_gnt_i = 1'b0;
        settle();
        chk("t4_req_after_rsp", mem_req_o, 1);
        tick();
        dp0_req_i = 1'b0; mem_gnt_i = 1'b1;
        for (int i = 1; i < MO; i++) sched(cyc, f(32'h600 + 32'(4 * i)));
        drain();
        auto_resp = 1'b1;

        // Response with empty FIFO sets sticky error until clear
        settle();
        chk("t5_err_before", err_o, 0);
        tick();
        sched(cyc, 32'hDEAD_BEEF);
        settle();
        chk("t5_no_rvalid", {dp1_r_valid_o, dp0_r_valid_o}, 0);
        tick();
        chk("t5_err_set", err_o, 1);
        repeat (2) begin
            settle();
            tick();
        end
        chk("t5_err_sticky", err_o, 1);
        clear_i = 1'b1; settle(); tick(); clear_i = 1'b0;
        chk("t5_err_cleared", err_o, 0);
        // FIFO still consistent after the stray response
        dp1_req_i = 1'b1; dp1_add_i = 32'h700;
        expect_rsp(1'b1, 32'h700);
        settle();
        chk("t5_gnt_after_err", {dp1_gnt_o, dp0_gnt_o}, 2'b10);
        tick();
        dp1_req_i = 1'b0;
        drain();

`ifdef DP_TCDM_ARB_LOCK_EN
        // Burst lock keeps dp0 winning; dp1 next once lock drops
        clear_i = 1'b1; settle(); tick(); clear_i = 1'b0;
        dp0_lock_i = 1'b1;
        dp0_req_i = 1'b1; dp0_add_i = 32'h800;
        dp1_req_i = 1'b1; dp1_add_i = 32'h900;
        for (int i = 0; i < 4; i++) begin
            expect_rsp(1'b0, 32'h800);
            settle();
            chk("t6_lock_gnt", {dp1_gnt_o, dp0_gnt_o}, 2'b01);
            tick();
        end
        dp0_lock_i = 1'b0;
        expect_rsp(1'b1, 32'h900);
        settle();
        chk("t6_unlock_gnt", {dp1_gnt_o, dp0_gnt_o}, 2'b10);
        tick();
        dp0_req_i = 1'b0; dp1_req_i = 1'b0;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
